// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage / data memory and the load-store unit.
// The master side is the environment: it presents accesses and returns the
// combinational memory read word; the slave side is the load-store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_Memwrite;
    logic        mem_Memread;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_load, req_store, funct3, addr, store_data, mem_read_data,
        input  req_ready, load_data, load_valid, fault, fault_code,
               mem_address, mem_write_data, mem_Memwrite, mem_Memread
    );

    modport slave (
        input  req_valid, req_load, req_store, funct3, addr, store_data, mem_read_data,
        output req_ready, load_data, load_valid, fault, fault_code,
               mem_address, mem_write_data, mem_Memwrite, mem_Memread
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load-store unit in front of a word-wide data memory with a
// combinational read port. Sub-word stores are done as read-modify-write.
//
//   state  | meaning
//   IDLE   | ready for an access; loads and word stores complete here
//   RMW_WR | writing back the merged word of an accepted sb/sh
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        is_access;
    logic        f3_ok;
    logic        out_of_range;
    logic        misaligned;
    logic [1:0]  code;
    logic        legal_load;
    logic        legal_store;
    logic        store_word;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_word;
    logic [31:0] merged_word;

    logic [29:0] rmw_index;
    logic [31:0] rmw_word;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr_c;
    logic [31:0] mem_wdata_c;

    assign bus.req_ready = rst_n && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_access     = bus.req_load || bus.req_store;

    // Classify the presented access; illegal beats out-of-range beats misaligned.
    always_comb begin
        f3_ok = 1'b0;
        case (bus.funct3)
            3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
            3'd4, 3'd5:       f3_ok = bus.req_load;
            default:          f3_ok = 1'b0;
        endcase
        if (bus.req_load && bus.req_store) begin
            f3_ok = 1'b0;
        end
        out_of_range = ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS));
        misaligned   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                       ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        code = 2'd0;
        if (!is_access) begin
            code = 2'd0;
        end else if (!f3_ok) begin
            code = 2'd3;
        end else if (out_of_range) begin
            code = 2'd2;
        end else if (misaligned) begin
            code = 2'd1;
        end
    end

    assign legal_load  = accept && bus.req_load  && (code == 2'd0);
    assign legal_store = accept && bus.req_store && (code == 2'd0);
    assign store_word  = (bus.funct3[1:0] == 2'b10);

    // Pick the addressed lane, extend it, and build the merged word for sb/sh.
    always_comb begin
        lane_byte = 8'd0;
        case (bus.addr[1:0])
            2'd0: lane_byte = bus.mem_read_data[7:0];
            2'd1: lane_byte = bus.mem_read_data[15:8];
            2'd2: lane_byte = bus.mem_read_data[23:16];
            2'd3: lane_byte = bus.mem_read_data[31:24];
            default: lane_byte = 8'd0;
        endcase
        lane_half = bus.addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

        load_word = bus.mem_read_data;
        case (bus.funct3)
            3'd0:    load_word = {{24{lane_byte[7]}}, lane_byte};
            3'd1:    load_word = {{16{lane_half[15]}}, lane_half};
            3'd4:    load_word = {24'd0, lane_byte};
            3'd5:    load_word = {16'd0, lane_half};
            default: load_word = bus.mem_read_data;
        endcase

        merged_word = bus.mem_read_data;
        if (bus.funct3[1:0] == 2'b00) begin
            case (bus.addr[1:0])
                2'd0: merged_word[7:0]   = bus.store_data[7:0];
                2'd1: merged_word[15:8]  = bus.store_data[7:0];
                2'd2: merged_word[23:16] = bus.store_data[7:0];
                2'd3: merged_word[31:24] = bus.store_data[7:0];
                default: merged_word = bus.mem_read_data;
            endcase
        end else if (bus.addr[1]) begin
            merged_word[31:16] = bus.store_data[15:0];
        end else begin
            merged_word[15:0] = bus.store_data[15:0];
        end
    end

    // Next state and memory strobes; everything idles at zero by default.
    always_comb begin
        state_next  = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr_c  = 32'd0;
        mem_wdata_c = 32'd0;
        case (state)
            IDLE: begin
                if (legal_load) begin
                    mem_read   = 1'b1;
                    mem_addr_c = {2'b00, bus.addr[31:2]};
                end else if (legal_store) begin
                    mem_addr_c = {2'b00, bus.addr[31:2]};
                    if (store_word) begin
                        mem_write   = 1'b1;
                        mem_wdata_c = bus.store_data;
                    end else begin
                        mem_read   = 1'b1;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_write   = 1'b1;
                mem_addr_c  = {2'b00, rmw_index};
                mem_wdata_c = rmw_word;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset kills the strobes immediately so a pending RMW write is dropped.
    assign bus.mem_Memread    = rst_n && mem_read;
    assign bus.mem_Memwrite   = rst_n && mem_write;
    assign bus.mem_address    = rst_n ? mem_addr_c  : 32'd0;
    assign bus.mem_write_data = rst_n ? mem_wdata_c : 32'd0;

    // State register and the registered load/fault results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.load_data  <= 32'd0;
            bus.load_valid <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_code <= 2'd0;
        end else begin
            state          <= state_next;
            bus.load_valid <= legal_load;
            if (legal_load) begin
                bus.load_data <= load_word;
            end
            bus.fault      <= accept && (code != 2'd0);
            bus.fault_code <= accept ? code : 2'd0;
        end
    end

    // Capture the merged word and its index for the RMW write-back cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rmw_index <= 30'd0;
            rmw_word  <= 32'd0;
        end else if (legal_store && !store_word) begin
            rmw_index <= bus.addr[31:2];
            rmw_word  <= merged_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random traffic,
// all checked every cycle against a word-array model of the memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory driven by the DUT, plus a poke port used to preload words.
    logic [31:0] mem     [32] = '{default: 32'd0};
    logic [31:0] ref_mem [32] = '{default: 32'd0};
    logic        poke_en  = 1'b0;
    logic [4:0]  poke_idx = 5'd0;
    logic [31:0] poke_val = 32'd0;

    assign bus.mem_read_data = mem[bus.mem_address[4:0]];

    always @(posedge clk) begin
        if (bus.mem_Memwrite) mem[bus.mem_address[4:0]] <= bus.mem_write_data;
        if (poke_en) mem[poke_idx] <= poke_val;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic        busy      = 1'b0;
    logic [4:0]  pend_idx  = 5'd0;
    logic [31:0] pend_word = 32'd0;
    logic        exp_lv    = 1'b0;
    logic [31:0] exp_ld    = 32'd0;
    logic        exp_f     = 1'b0;
    logic [1:0]  exp_fc    = 2'd0;

    logic        last_ready, last_rd, last_wr, last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] m_code(input logic ld, input logic st,
                                          input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!ld && !st) return 2'd0;
        if (ld && st) return 2'd3;
        if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 2'd3;
        if (st && f3 > 2) return 2'd3;
        if (a / 4 >= 32) return 2'd2;
        size = 1 << (f3 % 4);
        if (a % size != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
        int          sh;
        int          nbytes;
        logic [63:0] mask;
        logic [63:0] v;
        sh     = int'(a % 4) * 8;
        nbytes = 1 << (f3 % 4);
        mask   = (64'd1 << (nbytes * 8)) - 64'd1;
        v      = ({32'd0, word} >> sh) & mask;
        if (f3 < 4 && v[nbytes*8-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [31:0] a,
                                            input logic [2:0] f3, input logic [31:0] d);
        int          sh;
        int          nbytes;
        logic [63:0] mask;
        logic [63:0] w;
        sh     = int'(a % 4) * 8;
        nbytes = 1 << (f3 % 4);
        mask   = (64'd1 << (nbytes * 8)) - 64'd1;
        w      = {32'd0, word};
        w      = (w & ~(mask << sh)) | (({32'd0, d} & mask) << sh);
        return w[31:0];
    endfunction

    // One clock cycle: drive, check strobes, advance model, check results.
    task automatic step(input logic r, input logic v, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic        e_ready, e_rd, e_wr, acc, legal;
        logic [31:0] e_addr, e_wd;
        logic [1:0]  code;
        logic [4:0]  idx;
        int          bad;
        rst_n          = r;
        bus.req_valid  = v;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        #1;
        e_ready = r && !busy;
        acc     = v && e_ready;
        code    = m_code(ld, st, f3, a);
        legal   = acc && (code == 2'd0) && (ld || st);
        idx     = a[6:2];
        e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'd0; e_wd = 32'd0;
        if (r && busy) begin
            e_wr = 1'b1; e_addr = {27'd0, pend_idx}; e_wd = pend_word;
        end else if (legal && ld) begin
            e_rd = 1'b1; e_addr = a >> 2;
        end else if (legal && f3 == 3'd2) begin
            e_wr = 1'b1; e_addr = a >> 2; e_wd = d;
        end else if (legal) begin
            e_rd = 1'b1; e_addr = a >> 2;
        end
        last_ready = bus.req_ready;
        last_rd    = bus.mem_Memread;
        last_wr    = bus.mem_Memwrite;
        last_acc   = acc;
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, e_ready});
        chk("mem_Memread", {31'd0, bus.mem_Memread}, {31'd0, e_rd});
        chk("mem_Memwrite", {31'd0, bus.mem_Memwrite}, {31'd0, e_wr});
        chk("mem_address", bus.mem_address, e_addr);
        chk("mem_write_data", bus.mem_write_data, e_wd);
        chk("rd_wr_exclusive", {31'd0, bus.mem_Memread && bus.mem_Memwrite}, 32'd0);
        if (!r) begin
            busy = 1'b0; exp_lv = 1'b0; exp_ld = 32'd0; exp_f = 1'b0; exp_fc = 2'd0;
        end else begin
            if (busy) ref_mem[pend_idx] = pend_word;
            if (legal && st && f3 == 3'd2) ref_mem[idx] = d;
            exp_lv = legal && ld;
            if (exp_lv) exp_ld = m_load(ref_mem[idx], a, f3);
            exp_f  = acc && (code != 2'd0);
            exp_fc = exp_f ? code : 2'd0;
            busy   = legal && st && (f3 != 3'd2);
            if (busy) begin
                pend_idx  = idx;
                pend_word = m_store(ref_mem[idx], a, f3, d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("load_valid", {31'd0, bus.load_valid}, {31'd0, exp_lv});
        chk("load_data", bus.load_data, exp_ld);
        chk("fault", {31'd0, bus.fault}, {31'd0, exp_f});
        chk("fault_code", {30'd0, bus.fault_code}, {30'd0, exp_fc});
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic poke(input logic [4:0] i, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = i; poke_val = val;
        ref_mem[i] = val;
        idle();
        poke_en = 1'b0;
    endtask

    logic        h_pend;
    logic        s_r, s_v, s_ld, s_st;
    logic [2:0]  s_f3;
    logic [31:0] s_a, s_d;
    int          kind;

    initial begin
        // Model pins
        chk("model_lb", m_load(32'h8899AABB, 32'h0D, 3'd0), 32'hFFFFFFAA);
        chk("model_lhu", m_load(32'h8899AABB, 32'h0E, 3'd5), 32'h00008899);
        chk("model_sh", m_store(32'h11223344, 32'h0A, 3'd1, 32'h0000CAFE), 32'hCAFE3344);
        chk("model_code", {30'd0, m_code(1'b1, 1'b0, 3'd2, 32'h06)}, 32'd1);

        // Reset
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("reset_ready", {31'd0, last_ready}, 32'd0);
        chk("reset_load_data", bus.load_data, 32'd0);
        for (int i = 0; i < 32; i++) poke(i[4:0], $urandom);

        // lb / lbu sign handling
        poke(5'd3, 32'h8899AABB);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0D, 32'h0);
        chk("lb_valid", {31'd0, bus.load_valid}, 32'd1);
        chk("lb_data", bus.load_data, 32'hFFFFFFAA);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 32'h0D, 32'h0);
        chk("lbu_data", bus.load_data, 32'h000000AA);

        // sh then sb read-modify-write
        poke(5'd2, 32'h11223344);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0A, 32'h0000CAFE);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h08, 32'h00000055);
        chk("rmw_ready_low", {31'd0, last_ready}, 32'd0);
        chk("sh_result", mem[2], 32'hCAFE3344);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h08, 32'h00000055);
        idle();
        chk("sb_result", mem[2], 32'hCAFE3355);

        // Faults
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h06, 32'h0);
        chk("misalign_fault", {29'd0, bus.fault, bus.fault_code}, 32'h5);
        chk("misalign_no_mem", {30'd0, last_rd, last_wr}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h80, 32'h12345678);
        chk("range_fault", {29'd0, bus.fault, bus.fault_code}, 32'h6);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h04, 32'h0);
        chk("illegal_fault", {29'd0, bus.fault, bus.fault_code}, 32'h7);

        // sw then lw back to back
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("sw_lw_data", bus.load_data, 32'hDEADBEEF);
        chk("sw_lw_valid", {31'd0, bus.load_valid}, 32'd1);

        // Reset during RMW_WR
        poke(5'd5, 32'h0BADF00D);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h14, 32'h00000077);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("rst_rmw_no_write", {31'd0, last_wr}, 32'd0);
        chk("rst_rmw_word", mem[5], 32'h0BADF00D);
        idle();
        chk("rst_rmw_ready", {31'd0, last_ready}, 32'd1);
        chk("rst_rmw_outputs", {bus.load_data[29:0], bus.load_valid, bus.fault}, 32'd0);

        // Random traffic
        h_pend = 1'b0;
        s_v = 1'b0; s_ld = 1'b0; s_st = 1'b0; s_f3 = 3'd0; s_a = 32'd0; s_d = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            s_r = ($urandom_range(0, 59) != 0);
            if (!h_pend) begin
                s_v  = ($urandom_range(0, 3) != 0);
                kind = $urandom_range(0, 19);
                s_ld = (kind < 10);
                s_st = (kind >= 10) || (kind == 0);
                s_f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) begin
                    if (s_ld && !s_st) begin
                        case ($urandom_range(0, 4))
                            0: s_f3 = 3'd0;
                            1: s_f3 = 3'd1;
                            2: s_f3 = 3'd2;
                            3: s_f3 = 3'd4;
                            default: s_f3 = 3'd5;
                        endcase
                    end else begin
                        s_f3 = 3'($urandom_range(0, 2));
                    end
                end
                if ($urandom_range(0, 19) == 0) s_a = $urandom;
                else if ($urandom_range(0, 9) == 0) s_a = $urandom_range(128, 160);
                else s_a = $urandom_range(0, 127);
                s_d = $urandom;
            end
            step(s_r, s_v, s_ld, s_st, s_f3, s_a, s_d);
            h_pend = s_v && !last_acc;
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
